// File: rtl/hs_pkg.sv
// Shared definitions for the req/data/ack handshake: default widths and the
// responder FSM state encoding, used by the initiator, the responder and their benches.
package hs_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_e;

endpackage

// File: rtl/hs_responder_if.sv
// Bundle of the handshake, downstream stream and error-status signals.
// The master side is the initiator plus downstream sink; the slave side is the responder.
interface hs_responder_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic          req;
  logic [DW-1:0] data;
  logic          ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          seq_err;
  logic [CW-1:0] err_count;
  logic          err_clr;

  modport master (
    output req, data, out_ready, err_clr,
    input  ack, out_valid, out_data, level, seq_err, err_count
  );

  modport slave (
    input  req, data, out_ready, err_clr,
    output ack, out_valid, out_data, level, seq_err, err_count
  );

endinterface

// File: rtl/hs_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output and extra-bit wrap pointers.
// Push and pop on the same edge are legal even when full.
module hs_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [DW-1:0]            head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  // Gate the head so stale storage is never visible while empty.
  assign head_o  = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/hs_responder.sv
// Responder end of the req/data/ack handshake: captures words into a FIFO,
// acknowledges each with a one-cycle pulse and checks the words count up by one.
module hs_responder
  import hs_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  hs_responder_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] fifo_head;
  logic          push;
  logic          pop;

  hs_state_e     state_q;
  logic          ack_q;
  logic [DW-1:0] exp_q, exp_d;
  logic          exp_valid_q, exp_valid_d;
  logic          seq_err_q, seq_err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [CW-1:0] err_cnt_base;
  logic          mismatch;

  assign pop  = !fifo_empty && bus.out_ready;
  // A full FIFO may still accept when the head leaves on the same edge.
  assign push = (state_q == IDLE) && bus.req && (!fifo_full || pop);

  hs_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (bus.data),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level),
    .head_o      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= push;
          if (push) state_q <= ACK;
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          ack_q <= 1'b0;
          if (!bus.req) state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Clear is applied first so a mismatch on the same edge counts from zero.
  always_comb begin
    mismatch     = push && exp_valid_q && (bus.data != exp_q);
    err_cnt_base = bus.err_clr ? '0 : err_cnt_q;
    err_cnt_d    = err_cnt_base;
    seq_err_d    = seq_err_q && !bus.err_clr;
    exp_d        = exp_q;
    exp_valid_d  = exp_valid_q;
    if (mismatch) begin
      seq_err_d = 1'b1;
      if (err_cnt_base != '1) err_cnt_d = err_cnt_base + {{(CW-1){1'b0}}, 1'b1};
    end
    if (push) begin
      exp_d       = bus.data + {{(DW-1){1'b0}}, 1'b1};
      exp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q       <= '0;
      exp_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      exp_q       <= exp_d;
      exp_valid_q <= exp_valid_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.level     = fifo_level;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_hs_responder.sv
// Directed bench for hs_responder: a per-cycle vector table for the streaming
// scenarios plus hand-written sequences for backpressure, held req, reset and saturation.
module tb_hs_responder;
  import hs_pkg::*;

  typedef struct {
    logic        rst;
    logic        req;
    logic [31:0] data;
    logic        ordy;
    logic        clr;
    logic        ack;
    logic        ov;
    logic [31:0] od;
    logic [2:0]  lvl;
    logic        se;
    logic [7:0]  ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  hs_responder_if #(.DW(32), .DEPTH(4), .CW(8)) bus ();

  hs_responder #(.DW(32), .DEPTH(4), .CW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic vec_t mk(logic rst, logic req, logic [31:0] data, logic ordy, logic clr,
                              logic ack, logic ov, logic [31:0] od, logic [2:0] lvl,
                              logic se, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.data = data; v.ordy = ordy; v.clr = clr;
    v.ack = ack; v.ov = ov; v.od = od; v.lvl = lvl; v.se = se; v.ec = ec;
    return v;
  endfunction

  // One word through the handshake with a always-ready sink: capture, ack cycle, req low.
  task automatic add_word(input logic [31:0] w, input logic clr, input logic se, input logic [7:0] ec);
    vecs.push_back(mk(1'b0, 1'b1, w, 1'b1, clr, 1'b1, 1'b1, w, 3'd1, se, ec));
    vecs.push_back(mk(1'b0, 1'b1, w, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, se, ec));
    vecs.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, se, ec));
  endtask

  task automatic add_reset();
    vecs.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 8'd0));
  endtask

  task automatic do_reset();
    bus.req = 1'b0; bus.data = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic chk, input logic se, input logic [7:0] ec);
    bus.req = 1'b1; bus.data = w;
    tick();
    if (chk) begin
      check($sformatf("send %h ack", w), 32'(bus.ack), 32'd1);
      check($sformatf("send %h seq_err", w), 32'(bus.seq_err), 32'(se));
      check($sformatf("send %h err_count", w), 32'(bus.err_count), 32'(ec));
    end
    tick();
    bus.req = 1'b0;
    tick();
  endtask

  initial begin
    int acks;
    bus.req = 1'b0; bus.data = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Basic stream 1..4
    add_reset();
    for (int w = 1; w <= 4; w++) add_word(32'(w), 1'b0, 1'b0, 8'd0);
    // Sequence error, clear-wins-on-same-edge, then explicit clear
    add_reset();
    add_word(32'd10, 1'b0, 1'b0, 8'd0);
    add_word(32'd11, 1'b0, 1'b0, 8'd0);
    add_word(32'd13, 1'b0, 1'b1, 8'd1);
    add_word(32'd14, 1'b0, 1'b1, 8'd1);
    add_word(32'd16, 1'b1, 1'b1, 8'd1);
    vecs.push_back(mk(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 8'd0));
    add_word(32'd17, 1'b0, 1'b0, 8'd0);
    // Modulo-2^32 wrap, then a real error to show checking is live
    add_reset();
    add_word(32'hFFFF_FFFE, 1'b0, 1'b0, 8'd0);
    add_word(32'hFFFF_FFFF, 1'b0, 1'b0, 8'd0);
    add_word(32'h0000_0000, 1'b0, 1'b0, 8'd0);
    add_word(32'h0000_0002, 1'b0, 1'b1, 8'd1);

    foreach (vecs[i]) begin
      vec_t v;
      logic [75:0] got, want;
      v = vecs[i];
      bus.req = v.req; bus.data = v.data; bus.out_ready = v.ordy; bus.err_clr = v.clr;
      if (v.rst) rst_n = 1'b0;
      tick();
      got  = {bus.ack, bus.out_valid, bus.out_data, bus.level, bus.seq_err, bus.err_count, 30'd0};
      want = {v.ack, v.ov, v.od, v.lvl, v.se, v.ec, 30'd0};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL vec%0d: got ack=%0b ov=%0b od=%h lvl=%0d se=%0b ec=%0d, want ack=%0b ov=%0b od=%h lvl=%0d se=%0b ec=%0d",
                 i, bus.ack, bus.out_valid, bus.out_data, bus.level, bus.seq_err, bus.err_count,
                 v.ack, v.ov, v.od, v.lvl, v.se, v.ec);
      end else begin
        $display("[TB] vec%0d req=%0b data=%h ack=%0b od=%h lvl=%0d ec=%0d ok",
                 i, v.req, v.data, bus.ack, bus.out_data, bus.level, bus.err_count);
      end
      rst_n = 1'b1;
    end
    bus.err_clr = 1'b0;

    // Backpressure: fill to DEPTH, then pop and capture on the same edge
    do_reset();
    for (int w = 1; w <= 4; w++) send_word(32'(w), 1'b1, 1'b0, 8'd0);
    check("bp full level", 32'(bus.level), 32'd4);
    check("bp head", bus.out_data, 32'd1);
    bus.req = 1'b1; bus.data = 32'd5;
    acks = 0;
    repeat (3) begin
      tick();
      acks += int'(bus.ack);
    end
    check("bp withheld acks", 32'(acks), 32'd0);
    check("bp held level", 32'(bus.level), 32'd4);
    bus.out_ready = 1'b1;
    tick();
    $display("[TB] bp pop+push ack=%0b lvl=%0d head=%h", bus.ack, bus.level, bus.out_data);
    check("bp pop+push ack", 32'(bus.ack), 32'd1);
    check("bp pop+push level", 32'(bus.level), 32'd4);
    check("bp pop+push head", bus.out_data, 32'd2);
    bus.out_ready = 1'b0;
    tick();
    bus.req = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("bp drain %0d", k), bus.out_data, 32'(k));
      tick();
    end
    check("bp drained valid", 32'(bus.out_valid), 32'd0);

    // Held req: one capture only, FSM waits for req low
    do_reset();
    bus.req = 1'b1; bus.data = 32'd7;
    acks = 0;
    repeat (10) begin
      tick();
      acks += int'(bus.ack);
    end
    $display("[TB] held req acks=%0d lvl=%0d", acks, bus.level);
    check("held acks", 32'(acks), 32'd1);
    check("held level", 32'(bus.level), 32'd1);
    bus.req = 1'b0;
    tick();
    bus.req = 1'b1; bus.data = 32'd8;
    tick();
    check("held recapture ack", 32'(bus.ack), 32'd1);
    check("held recapture level", 32'(bus.level), 32'd2);
    check("held recapture seq_err", 32'(bus.seq_err), 32'd0);
    bus.req = 1'b0;
    tick();
    tick();

    // Asynchronous reset while in ACK with two words buffered
    do_reset();
    send_word(32'd1, 1'b0, 1'b0, 8'd0);
    bus.req = 1'b1; bus.data = 32'd2;
    tick();
    check("mid ack before reset", 32'(bus.ack), 32'd1);
    check("mid level before reset", 32'(bus.level), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset ack=%0b ov=%0b lvl=%0d", bus.ack, bus.out_valid, bus.level);
    check("async ack", 32'(bus.ack), 32'd0);
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async level", 32'(bus.level), 32'd0);
    bus.req = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_word(32'd50, 1'b1, 1'b0, 8'd0);
    send_word(32'd51, 1'b1, 1'b0, 8'd0);
    send_word(32'd53, 1'b1, 1'b1, 8'd1);

    // Error counter saturation: every word after the first mismatches
    do_reset();
    bus.out_ready = 1'b1;
    for (int n = 1; n <= 258; n++) begin
      send_word(32'd0, 1'b0, 1'b0, 8'd0);
      if (n == 100) check("sat count at 99 errors", 32'(bus.err_count), 32'd99);
    end
    $display("[TB] saturation err_count=%0d seq_err=%0b", bus.err_count, bus.seq_err);
    check("sat count", 32'(bus.err_count), 32'd255);
    check("sat flag", 32'(bus.seq_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_responder.md
Name: hs_responder

Overview:
- Responder end of the req/data/ack handshake. It accepts 32-bit words from an initiator, buffers them in a small FIFO and presents them downstream on a valid/ready stream.
- It checks that the initiator's word sequence increments by one per transfer and flags violations.
- It sits in the same clk domain as its initiator. CDC is handled elsewhere.

Parameters:
- DW, 32, payload width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  initiator request; data valid while high
- data  in  DW  initiator payload
- ack  out  1  registered single-cycle acknowledge pulse
- out_valid  out  1  FIFO head valid
- out_data  out  DW  FIFO head word (show-ahead)
- out_ready  in  1  downstream accept; transfer = out_valid & out_ready
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- seq_err  out  1  sticky sequence-violation flag
- err_count  out  CW  saturating count of violations
- err_clr  in  1  synchronous clear of seq_err and err_count

Behaviour:
- Reset values:
  - ack=0, out_valid=0, out_data=0, level=0, seq_err=0, err_count=0.
  - FSM in IDLE; FIFO pointers 0; exp_valid=0.
- FSM states:
  - IDLE: if req & !full, push data into FIFO at this edge, go to ACK. If req & full, stay in IDLE (backpressure; ack withheld, req held).
  - ACK: ack=1 for exactly this one cycle; go to WAIT_LOW unconditionally.
  - WAIT_LOW: ack=0; go to IDLE when req==0. A req still high here is never re-captured.
- Latency and throughput:
  - Capture happens on the first edge where IDLE sees req=1.
  - ack is high during the following cycle.
  - Against a registered initiator that drops req on ack and re-raises it one cycle later, throughput is 1 word per 3 cycles.
- FIFO:
  - DEPTH entries with extra-bit wrap pointers.
  - full when level==DEPTH; empty when level==0.
  - out_valid = !empty; out_data = mem[rd_ptr].
  - Simultaneous push and pop: level unchanged. Legal when full, because the pop frees the slot that same edge; IDLE may capture when full & out_ready & out_valid.
  - Pointers wrap modulo 2*DEPTH; no overflow or underflow is possible by construction.
- Sequence check, on each capture:
  - If exp_valid==0: set expected=data+1, exp_valid=1, no check.
  - Otherwise: if data != expected, set seq_err=1 and increment err_count (saturating at 2^CW-1). Then expected=data+1 regardless.
  - Arithmetic is modulo 2^DW: 32'hFFFFFFFF followed by 0 is legal.
- err_clr:
  - Clears seq_err and err_count on the next edge.
  - Capture with a mismatch on the same edge: clear wins, then count=1, flag=1.
  - Does not touch exp_valid.
- Reset mid-operation (any state): everything returns to reset values; FIFO contents are discarded; the next word re-seeds expected.

Decomposition:
- Package hs_pkg:
  - DW default.
  - FSM state enum (IDLE, ACK, WAIT_LOW).
  - Shared with the initiator and its bench.
- One sub-module: hs_sync_fifo (DEPTH/DW parameterised, push/pop/full/empty/level, show-ahead read).
- FSM and sequence checker stay in hs_responder.

Test Plan:
- Basic transfer:
  - Stimulus: reset, initiator sends 1,2,3,4 with out_ready=1.
  - Response: ack pulses one cycle each, 3 cycles apart; out_data stream 1,2,3,4; seq_err=0.
- Backpressure:
  - Stimulus: out_ready=0, DEPTH=4, initiator sends 1..6.
  - Response: four acks; level=4; req held high with ack=0.
  - Then out_ready=1 for one cycle: word 1 popped, word 5 captured on the same edge, level stays 4.
- Sequence error:
  - Stimulus: send 10,11,13,14.
  - Response: seq_err=1 after 13, err_count=1, no further increment on 14.
  - Then err_clr pulse: both clear.
- Wrap:
  - Stimulus: send 32'hFFFFFFFE, 32'hFFFFFFFF, 0.
  - Response: seq_err stays 0.
- Held req:
  - Stimulus: initiator holds req=1 for 10 cycles with constant data.
  - Response: exactly one capture and one ack; FSM stays in WAIT_LOW until req falls.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in ACK with level=2.
  - Response: ack, out_valid and level go to 0 immediately (async). After release, first word re-seeds the checker, no error.
